uart_rx_deserializer: RTL and testbench

- Receive front end of the UART peripheral. Sits directly upstream of the RX FIFO.
- Synchronises the asynchronous rx pin and detects start bits on the 16x oversample tick from the UART clock divider.
- Deserialises 5–8 data bits with optional parity and 1 or 2 stop bits.
- Emits one write strobe per received character plus per-character error flags.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_ff.sv | 21 ++
 rtl/uart_rx_deserializer.sv | 140 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_type_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_rx_state_t;

  localparam int UART_MIN_DATA_BITS = 5;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for asynchronous inputs, with a selectable reset value.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= {STAGES{RESET_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: oversampled start detect, 5-8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority around the mid-bit tick.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] DEC_PH  = PW'(OVERSAMPLE/2);
  localparam logic [PW-1:0] LAST_PH = PW'(OVERSAMPLE-1);

  uart_rx_state_t state;
  logic [PW-1:0]  phase;
  logic [3:0]     bitcnt;
  logic [7:0]     sr;
  logic           pbit, stop_err, armed;
  logic [1:0]     cfg_bits, cfg_par;
  logic           cfg_two;
  logic           rx_s, bitval;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
    .clk(clk), .reset(reset), .d(rx), .q(rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [PW-1:0] M0_PH = PW'(OVERSAMPLE/2 - 2);
  localparam logic [PW-1:0] M1_PH = PW'(OVERSAMPLE/2 - 1);
  logic [1:0] maj_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) maj_s <= 2'b11;
    else if (sample_tick) begin
      if (phase == M0_PH) maj_s[0] <= rx_s;
      if (phase == M1_PH) maj_s[1] <= rx_s;
    end
  end

  assign bitval = (maj_s[0] & maj_s[1]) | (maj_s[0] & rx_s) | (maj_s[1] & rx_s);
`else
  assign bitval = rx_s;
`endif

  logic       dec, wrap, par_en, finish, par_x;
  logic [3:0] nbits;
  logic [7:0] data_out;

  assign dec      = sample_tick && (phase == DEC_PH);
  assign wrap     = sample_tick && (phase == LAST_PH);
  assign par_en   = (cfg_par == PAR_ODD) || (cfg_par == PAR_EVEN);
  assign nbits    = 4'(UART_MIN_DATA_BITS) + {2'b00, cfg_bits};
  // Characters are shifted in from the MSB, so short ones sit left-aligned in sr.
  assign data_out = sr >> (2'd3 - cfg_bits);
  assign par_x    = (^data_out) ^ pbit;
  assign finish   = dec && (((state == STOP1) && !cfg_two) || (state == STOP2));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;  phase <= '0;    bitcnt <= '0;  sr <= '0;
      pbit <= 1'b0;   stop_err <= 1'b0; armed <= 1'b0;
      cfg_bits <= '0; cfg_par <= '0;  cfg_two <= 1'b0;
      dout <= '0;     valid <= 1'b0;  parity_err <= 1'b0; frame_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sample_tick) begin
        phase <= phase + 1'b1;
        case (state)
          IDLE: begin
            phase <= '0;
            // A start edge only counts after the line has been seen high (break recovery).
            if (rx_s) armed <= 1'b1;
            else if (armed) begin
              state    <= START;
              phase    <= PW'(1);
              armed    <= 1'b0;
              sr       <= '0;
              stop_err <= 1'b0;
              cfg_bits <= data_bits_count;
              cfg_par  <= parity_type;
              cfg_two  <= double_stop_bits;
            end
          end
          START: begin
            if (dec && bitval) begin
              state <= IDLE;
              phase <= '0;
              armed <= 1'b1;
            end else if (wrap) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            if (dec) begin
              sr     <= {bitval, sr[7:1]};
              bitcnt <= bitcnt + 1'b1;
            end
            if (wrap && (bitcnt == nbits)) state <= par_en ? PARITY : STOP1;
          end
          PARITY: begin
            if (dec)  pbit  <= bitval;
            if (wrap) state <= STOP1;
          end
          STOP1: begin
            if (dec)  stop_err <= !bitval;
            if (wrap) state    <= STOP2;
          end
          STOP2: ;
          default: state <= IDLE;
        endcase
        if (finish) begin
          state      <= IDLE;
          phase      <= '0;
          armed      <= bitval;
          valid      <= 1'b1;
          dout       <= data_out;
          parity_err <= (cfg_par == PAR_ODD)  ? !par_x :
                        (cfg_par == PAR_EVEN) ?  par_x : 1'b0;
          frame_err  <= !bitval || ((state == STOP2) && stop_err);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised self-checking bench for uart_rx_deserializer against a frame-level reference model.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bits_count = 2'd3;
  logic [1:0] parity_type = 2'd0;
  logic       double_stop_bits = 1'b0;
  logic [7:0] dout;
  logic       valid, parity_err, frame_err, busy;

  uart_rx_deserializer dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
    .data_bits_count(data_bits_count), .parity_type(parity_type),
    .double_stop_bits(double_stop_bits), .dout(dout), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // sample_tick: one clk in every four
  logic [1:0] tdiv = 2'd0;
  always @(negedge clk) begin
    tdiv        <= tdiv + 2'd1;
    sample_tick <= (tdiv == 2'd3);
  end

  int tick_no = 0;
  always @(posedge clk) if (sample_tick) tick_no <= tick_no + 1;

  int         vcount = 0;
  int         cap_tick = 0;
  logic [7:0] cap_d = '0;
  logic       cap_pe = 1'b0, cap_fe = 1'b0;
  always @(negedge clk) if (valid) begin
    vcount   <= vcount + 1;
    cap_tick <= tick_no;
    cap_d    <= dout;
    cap_pe   <= parity_err;
    cap_fe   <= frame_err;
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
      #1;
    end
  endtask

  int fall_tick;

  // Drives one frame LSB-first; optionally scrambles the config inputs after the start bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                            input logic two, input logic pb, input logic s1, input logic s2,
                            input logic scramble);
    data_bits_count  = 2'(nb - 5);
    parity_type      = par;
    double_stop_bits = two;
    rx = 1'b0;
    fall_tick = tick_no;
    wait_ticks(16);
    if (scramble) begin
      data_bits_count  = 2'($urandom);
      parity_type      = 2'($urandom);
      double_stop_bits = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rx = pb;
      wait_ticks(16);
    end
    rx = s1;
    wait_ticks(16);
    if (two) begin
      rx = s2;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(2);
  endtask

  // Reference model: what the receiver should report for a frame as sent on the line.
  task automatic model(input logic [7:0] d, input int nb, input logic [1:0] par,
                       input logic two, input logic pb, input logic s1, input logic s2,
                       output logic [7:0] ed, output logic epe, output logic efe);
    int ones;
    logic good_pb;
    ed   = 8'(d & ((1 << nb) - 1));
    ones = $countones(ed);
    if (par == 2'b01)      good_pb = (ones % 2 == 0);
    else if (par == 2'b10) good_pb = (ones % 2 == 1);
    else                   good_pb = pb;
    epe = (pb != good_pb);
    efe = !s1 || (two && !s2);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int nb,
                           input logic [1:0] par, input logic two, input logic pb,
                           input logic s1, input logic s2, input logic scramble);
    logic [7:0] ed;
    logic epe, efe;
    int v0;
    model(d, nb, par, two, pb, s1, s2, ed, epe, efe);
    v0 = vcount;
    send_frame(d, nb, par, two, pb, s1, s2, scramble);
    chk({tag, ".nvalid"}, 32'(vcount - v0), 32'd1);
    chk({tag, ".dout"}, {24'd0, cap_d}, {24'd0, ed});
    chk({tag, ".perr"}, {31'd0, cap_pe}, {31'd0, epe});
    chk({tag, ".ferr"}, {31'd0, cap_fe}, {31'd0, efe});
  endtask

  initial begin
    int v0;
    logic [7:0] rd;
    int nb;
    logic [1:0] par;
    logic two, pb, s1, s2;

    #23;
    chk("rst.dout", {24'd0, dout}, 32'd0);
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.perr", {31'd0, parity_err}, 32'd0);
    chk("rst.ferr", {31'd0, frame_err}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5 with latency check
    run_frame("a5", 8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("a5.latency", 32'(cap_tick - fall_tick), 32'(9*16 + 8 + 1));

    // 7E1 parity
    run_frame("7e1bad", 8'h41, 7, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame("7e1ok", 8'h41, 7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 5 bits, two stop bits
    run_frame("5n2bad", 8'h15, 5, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("5n2ok", 8'h0A, 5, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // false start
    v0 = vcount;
    data_bits_count = 2'd3; parity_type = 2'b00; double_stop_bits = 1'b0;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(12);
    chk("fstart.nvalid", 32'(vcount - v0), 32'd0);
    chk("fstart.busy", {31'd0, busy}, 32'd0);
    run_frame("3c", 8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset in the middle of 0xFF
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(40);
    chk("midrst.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst.dout", {24'd0, dout}, 32'd0);
    chk("midrst.valid", {31'd0, valid}, 32'd0);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.ferr", {31'd0, frame_err}, 32'd0);
    wait_ticks(2);
    reset = 1'b1;
    wait_ticks(120);
    chk("midrst.nvalid", 32'(vcount - v0), 32'd0);
    run_frame("81", 8'h81, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // single-tick glitch in data bit 0 of 0x00
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(16);
`ifdef UART_RX_MAJORITY_EN
    wait_ticks(7); rx = 1'b1; wait_ticks(1); rx = 1'b0; wait_ticks(8);
`else
    wait_ticks(8); rx = 1'b1; wait_ticks(1); rx = 1'b0; wait_ticks(7);
`endif
    wait_ticks(7*16);
    rx = 1'b1;
    wait_ticks(18);
    chk("glitch.nvalid", 32'(vcount - v0), 32'd1);
`ifdef UART_RX_MAJORITY_EN
    chk("glitch.dout", {24'd0, cap_d}, 32'h00);
`else
    chk("glitch.dout", {24'd0, cap_d}, 32'h01);
`endif

    // break: line held low well past a frame
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(16*14);
    chk("break.nvalid", 32'(vcount - v0), 32'd1);
    chk("break.dout", {24'd0, cap_d}, 32'h00);
    chk("break.ferr", {31'd0, cap_fe}, 32'd1);
    chk("break.busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_ticks(3);
    run_frame("postbrk", 8'h5A, 8, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // randomised frames, config inputs scrambled mid-frame
    for (int f = 0; f < 30; f++) begin
      rd  = 8'($urandom);
      nb  = 5 + $urandom_range(0, 3);
      par = 2'($urandom);
      two = 1'($urandom);
      pb  = 1'($urandom);
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      run_frame("rand", rd, nb, par, two, pb, s1, s2, 1'b1);
      wait_ticks($urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
